// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, flag latch, next-PC selection and return-address stack
module pc_branch_unit #(
  parameter int WIDTH     = 16,
  parameter int INC       = 2,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             pcWriteEnable,
  input  logic [2:0]       pcSource,
  input  logic             cmpLatch,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] PC,
  output logic [1:0]       cmpRst,
  output logic             taken,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasErr
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] LP_INC      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] LP_RESET_PC = WIDTH'(RESET_PC);
  localparam logic [CW-1:0]    LP_DEPTH    = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_ABS  = 3'd1,
    SRC_BEQ  = 3'd2,
    SRC_BLT  = 3'd3,
    SRC_BNE  = 3'd4,
    SRC_CALL = 3'd5,
    SRC_RET  = 3'd6,
    SRC_RSV  = 3'd7
  } src_e;

  logic [WIDTH-1:0] r_pc;
  logic [1:0]       r_cmp;
  logic             r_taken;
  logic             r_err;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_rel;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_next_taken;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_lt;
  logic             w_eq;
  src_e             w_src;

  assign w_pc_inc = r_pc + LP_INC;
  assign w_pc_rel = r_pc + offset;
  assign w_top    = r_ras[r_ptr - PW'(1)];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == LP_DEPTH);
  assign w_lt     = ($signed(A) < $signed(B));
  assign w_eq     = (A == B);
  assign w_src    = src_e'(pcSource);

  // Next-PC selection; branches look only at the already-latched flags
  always_comb begin
    w_next_pc    = w_pc_inc;
    w_next_taken = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_underflow  = 1'b0;
    case (w_src)
      SRC_ABS: begin
        w_next_pc    = target;
        w_next_taken = 1'b1;
      end
      SRC_BEQ: if (r_cmp[0]) begin
        w_next_pc    = w_pc_rel;
        w_next_taken = 1'b1;
      end
      SRC_BLT: if (r_cmp[1]) begin
        w_next_pc    = w_pc_rel;
        w_next_taken = 1'b1;
      end
      SRC_BNE: if (!r_cmp[0]) begin
        w_next_pc    = w_pc_rel;
        w_next_taken = 1'b1;
      end
      SRC_CALL: begin
        w_next_pc    = target;
        w_next_taken = 1'b1;
        w_push       = 1'b1;
      end
      SRC_RET: begin
        if (w_empty) begin
          w_underflow = 1'b1;
        end else begin
          w_next_pc    = w_top;
          w_next_taken = 1'b1;
          w_pop        = 1'b1;
        end
      end
      default: begin
        w_next_pc    = w_pc_inc;
        w_next_taken = 1'b0;
      end
    endcase
  end

  // Comparator flag latch, independent of PC commit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_cmp <= 2'b00;
    end else if (cmpLatch) begin
      r_cmp <= {w_lt, w_eq};
    end
  end

  // PC, taken, stack pointer/count and sticky error update on commit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pc    <= LP_RESET_PC;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (pcWriteEnable) begin
      r_pc    <= w_next_pc;
      r_taken <= w_next_taken;
      if (w_push) begin
        // Pointer wraps, so a push into a full stack overwrites the oldest entry
        r_ptr <= r_ptr + PW'(1);
        if (w_full) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_pop) begin
        r_ptr <= r_ptr - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  // Return-address storage; contents are don't-care while the count is zero
  always_ff @(posedge CLK) begin
    if (pcWriteEnable && w_push) begin
      r_ras[r_ptr] <= w_pc_inc;
    end
  end

  assign PC       = r_pc;
  assign cmpRst   = r_cmp;
  assign taken    = r_taken;
  assign rasEmpty = w_empty;
  assign rasFull  = w_full;
  assign rasErr   = r_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - table-driven self-checking bench for pc_branch_unit
module tb_pc_branch_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        pcWriteEnable;
  logic [2:0]  pcSource;
  logic        cmpLatch;
  logic [15:0] A, B, target, offset;
  logic [15:0] PC;
  logic [1:0]  cmpRst;
  logic        taken, rasEmpty, rasFull, rasErr;

  int checks   = 0;
  int failures = 0;

  pc_branch_unit #(.WIDTH(16), .INC(2), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .CLK(CLK), .reset(reset), .pcWriteEnable(pcWriteEnable), .pcSource(pcSource),
    .cmpLatch(cmpLatch), .A(A), .B(B), .target(target), .offset(offset),
    .PC(PC), .cmpRst(cmpRst), .taken(taken), .rasEmpty(rasEmpty),
    .rasFull(rasFull), .rasErr(rasErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [2:0]  src;
    logic        lat;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tgt;
    logic [15:0] off;
    logic [15:0] pc;
    logic [1:0]  cmp;
    logic        tk;
    logic        em;
    logic        fu;
    logic        er;
  } vec_t;

  vec_t vt [19];

  function automatic vec_t mk(input logic we, input logic [2:0] src, input logic lat,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] tgt, input logic [15:0] off,
                              input logic [15:0] pc, input logic [1:0] cmp,
                              input logic tk, input logic em, input logic fu, input logic er);
    vec_t v;
    v.we = we; v.src = src; v.lat = lat; v.a = a; v.b = b; v.tgt = tgt; v.off = off;
    v.pc = pc; v.cmp = cmp; v.tk = tk; v.em = em; v.fu = fu; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [1:0] cmp,
                         input logic tk, input logic em, input logic fu, input logic er);
    chk({tag, ".PC"}, 32'(PC), 32'(pc));
    chk({tag, ".cmpRst"}, 32'(cmpRst), 32'(cmp));
    chk({tag, ".taken"}, 32'(taken), 32'(tk));
    chk({tag, ".rasEmpty"}, 32'(rasEmpty), 32'(em));
    chk({tag, ".rasFull"}, 32'(rasFull), 32'(fu));
    chk({tag, ".rasErr"}, 32'(rasErr), 32'(er));
  endtask

  task automatic drive(input logic we, input logic [2:0] src, input logic lat,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] tgt, input logic [15:0] off);
    pcWriteEnable = we; pcSource = src; cmpLatch = lat;
    A = a; B = b; target = tgt; offset = off;
  endtask

  task automatic step(input logic we, input logic [2:0] src, input logic [15:0] tgt);
    drive(we, src, 1'b0, 16'h0, 16'h0, tgt, 16'h0);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  localparam logic [2:0] SEQ = 3'd0, ABS = 3'd1, BEQ = 3'd2, BLT = 3'd3,
                         BNE = 3'd4, CALL = 3'd5, RET = 3'd6, RSV = 3'd7;

  initial begin
    //            we   src   lat  A        B        target   offset   PC       cmp    tk  em  fu  er
    vt[0]  = mk(1'b1, SEQ,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0002, 2'b00, 0, 1, 0, 0);
    vt[1]  = mk(1'b1, SEQ,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0004, 2'b00, 0, 1, 0, 0);
    vt[2]  = mk(1'b1, SEQ,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0006, 2'b00, 0, 1, 0, 0);
    vt[3]  = mk(1'b0, SEQ,  1'b1, 16'd5,   16'd5,   16'h0,   16'h0,   16'h0006, 2'b01, 0, 1, 0, 0);
    vt[4]  = mk(1'b1, BEQ,  1'b0, 16'h0,   16'h0,   16'h0,   16'hFFFC, 16'h0002, 2'b01, 1, 1, 0, 0);
    vt[5]  = mk(1'b1, BNE,  1'b0, 16'h0,   16'h0,   16'h0,   16'hFFFC, 16'h0004, 2'b01, 0, 1, 0, 0);
    // latch (1<2 -> lt) in the same edge as beq: beq must still see old eq=1
    vt[6]  = mk(1'b1, BEQ,  1'b1, 16'd1,   16'd2,   16'h0,   16'h0008, 16'h000C, 2'b10, 1, 1, 0, 0);
    vt[7]  = mk(1'b1, ABS,  1'b1, 16'hFFFD, 16'h0002, 16'hFFF8, 16'h0, 16'hFFF8, 2'b10, 1, 1, 0, 0);
    vt[8]  = mk(1'b1, BLT,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0010, 16'h0008, 2'b10, 1, 1, 0, 0);
    vt[9]  = mk(1'b1, RSV,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h000A, 2'b10, 0, 1, 0, 0);
    vt[10] = mk(1'b1, ABS,  1'b0, 16'h0,   16'h0,   16'h0020, 16'h0,  16'h0020, 2'b10, 1, 1, 0, 0);
    vt[11] = mk(1'b1, CALL, 1'b0, 16'h0,   16'h0,   16'h0100, 16'h0,  16'h0100, 2'b10, 1, 0, 0, 0);
    vt[12] = mk(1'b1, RET,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0022, 2'b10, 1, 1, 0, 0);
    vt[13] = mk(1'b1, RET,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0024, 2'b10, 0, 1, 0, 1);
    vt[14] = mk(1'b1, RET,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0026, 2'b10, 0, 1, 0, 1);
    // 2 vs -3: neither lt nor eq
    vt[15] = mk(1'b0, RET,  1'b1, 16'h0002, 16'hFFFD, 16'h0, 16'h0,   16'h0026, 2'b00, 0, 1, 0, 1);
    vt[16] = mk(1'b1, BLT,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0040, 16'h0028, 2'b00, 0, 1, 0, 1);
    vt[17] = mk(1'b1, BNE,  1'b0, 16'h0,   16'h0,   16'h0,   16'h0100, 16'h0128, 2'b00, 1, 1, 0, 1);
    vt[18] = mk(1'b0, CALL, 1'b0, 16'h0,   16'h0,   16'h0500, 16'h0,  16'h0128, 2'b00, 1, 1, 0, 1);

    // Reset state, including a clock edge with a commit request while reset is held
    reset = 1'b0;
    drive(1'b1, SEQ, 1'b1, 16'd7, 16'd7, 16'h0, 16'h0);
    #2;
    chk_all("reset", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    chk_all("reset_held", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, SEQ, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].we, vt[i].src, vt[i].lat, vt[i].a, vt[i].b, vt[i].tgt, vt[i].off);
      @(posedge CLK);
      @(negedge CLK);
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].cmp, vt[i].tk, vt[i].em, vt[i].fu, vt[i].er);
    end

    // Overflow: five calls into a 4-deep stack, then four returns
    do_reset();
    chk_all("ovf_reset", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, CALL, 16'(i * 16'h1000));
      chk_all($sformatf("ovf_call%0d", i), 16'(i * 16'h1000), 2'b00, 1'b1,
              1'b0, (i >= 4) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0);
    end
    for (int i = 5; i >= 2; i--) begin
      step(1'b1, RET, 16'h0);
      // call i was made from PC (i-1)*0x1000, so it pushed that + 2
      chk_all($sformatf("ovf_ret%0d", i), 16'((i - 1) * 16'h1000 + 2), 2'b00, 1'b1,
              (i == 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
    end

    // Hold with pcSource=call, then asynchronous reset with two entries stacked
    do_reset();
    step(1'b1, CALL, 16'h0300);
    step(1'b1, CALL, 16'h0400);
    chk_all("hold_pre", 16'h0400, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, CALL, 16'h0700);
      chk_all($sformatf("hold%0d", i), 16'h0400, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, RET, 16'h0);
    chk_all("hold_ret", 16'h0302, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, CALL, 16'h0600);
    chk_all("pre_async", 16'h0600, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, RET, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    step(1'b1, RET, 16'h0);
    chk_all("post_rst_ret", 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
